sdiv16_seq: RTL

SDIV16_SEQ -- requirements
Module: sdiv16_seq

---
 rtl/sdiv16_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sdiv16_seq.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit
// per cycle, followed by a sign-fix cycle and a one-cycle done pulse.
module sdiv16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivZero,
  output logic             oOverflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] oquo_q, oquo_d;
  logic [WIDTH-1:0] orem_q, orem_d;
  logic             odz_q, odz_d;
  logic             oov_q, oov_d;

  // Trial subtraction is one bit wider than the partial remainder so its MSB is the sign.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_bits;

  assign shifted     = {rem_q, quo_q[WIDTH-1]};
  assign diff        = shifted - {2'b00, dvs_q};
  assign unused_bits = shifted[WIDTH+1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    oquo_d  = oquo_q;
    orem_d  = orem_q;
    odz_d   = odz_q;
    oov_d   = oov_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          // Negating the most-negative value yields itself, which read unsigned is 2^(WIDTH-1).
          quo_d   = iDividend[WIDTH-1] ? -iDividend : iDividend;
          dvs_d   = iDivisor[WIDTH-1]  ? -iDivisor  : iDivisor;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          negq_d  = iDividend[WIDTH-1] ^ iDivisor[WIDTH-1];
          negr_d  = iDividend[WIDTH-1];
          dz_d    = (iDivisor == '0);
          ov_d    = (iDividend == MOST_NEG) && (iDivisor == '1);
          odz_d   = 1'b0;
          oov_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!diff[WIDTH+1]) begin
          rem_d = diff[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor leaves the dividend magnitude in the remainder already; only the quotient is forced.
        oquo_d  = dz_q ? '1 : (negq_q ? -quo_q : quo_q);
        orem_d  = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        odz_d   = dz_q;
        oov_d   = ov_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      oquo_q  <= '0;
      orem_q  <= '0;
      odz_q   <= 1'b0;
      oov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      oquo_q  <= oquo_d;
      orem_q  <= orem_d;
      odz_q   <= odz_d;
      oov_q   <= oov_d;
    end
  end

  assign oBusy      = (state_q == CALC) || (state_q == FIX);
  assign oDone      = (state_q == DONE);
  assign oQuotient  = oquo_q;
  assign oRemainder = orem_q;
  assign oDivZero   = odz_q;
  assign oOverflow  = oov_q;

endmodule
